// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction fetch stage
package if_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] IF_NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] IF_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, bubble and hold
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [XLEN-1:0] ifid_instr
);
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid <= 1'b0;
            ifid_pc <= '0;
            ifid_pc_plus4 <= '0;
            ifid_instr <= NOP_INSTR;
        end else if (bubble) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end else if (load) begin
            ifid_valid <= 1'b1;
            ifid_pc <= pc;
            ifid_pc_plus4 <= pc + 32'd4;
            ifid_instr <= instr;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, fetch FSM, misaligned-redirect trap and IF/ID register
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [XLEN-1:0] ifid_instr,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);
    state_t state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic run, misaligned, load, bubble, fault_set;
    assign imem_addr = pc;
    assign misaligned = |redirect_target[1:0];
    always_ff @(posedge clk) begin
        state <= reset ? BOOT : state_next;
    end
    always_comb begin
        state_next = (state == BOOT) ? RUN :
                     (state == RUN && redirect_valid && misaligned) ? HALT : state;
    end
    always_comb begin
        run = (state == RUN);
        bubble = !run || redirect_valid;
        load = run && !redirect_valid && !stall;
        fault_set = run && redirect_valid && misaligned;
        pc_next = (run && redirect_valid && !misaligned) ? redirect_target :
                  load ? pc + 32'd4 : pc;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            fetch_fault <= 1'b0;
            fault_pc <= '0;
        end else begin
            pc <= pc_next;
            if (fault_set) begin
                fetch_fault <= 1'b1;
                fault_pc <= redirect_target;
            end
        end
    end
    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .bubble        (bubble),
        .pc            (pc),
        .instr         (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_instr    (ifid_instr)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: vector table, corner sequences and randomized model check
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    logic reset, stall, redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_rdata, ifid_pc, ifid_pc_plus4, ifid_instr, fault_pc;
    logic ifid_valid, fetch_fault;
    logic [31:0] w_addr, w_rdata, w_pc, w_p4, w_instr, w_fpc;
    logic w_valid, w_fault;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
    endfunction

    assign imem_rdata = mem(imem_addr);
    assign w_rdata = mem(w_addr);

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_instr(ifid_instr), .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .ifid_valid(w_valid), .ifid_pc(w_pc), .ifid_pc_plus4(w_p4),
        .ifid_instr(w_instr), .fetch_fault(w_fault), .fault_pc(w_fpc)
    );

    typedef struct {
        logic rst, stl, rv;
        logic [31:0] tgt;
        logic e_valid;
        logic [31:0] e_addr, e_pc, e_p4, e_instr;
        logic e_fault;
        logic [31:0] e_fpc;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic [31:0] t);
        reset = r;
        stall = s;
        redirect_valid = v;
        redirect_target = t;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] a,
                             input logic [31:0] p, input logic [31:0] p4, input logic [31:0] ins,
                             input logic f, input logic [31:0] fp);
        chk({tag, " valid"}, {31'd0, ifid_valid}, {31'd0, v});
        chk({tag, " addr"}, imem_addr, a);
        chk({tag, " pc"}, ifid_pc, p);
        chk({tag, " pc4"}, ifid_pc_plus4, p4);
        chk({tag, " instr"}, ifid_instr, ins);
        chk({tag, " fault"}, {31'd0, fetch_fault}, {31'd0, f});
        chk({tag, " fpc"}, fault_pc, fp);
    endtask

    // behavioural model state: mode 0 boot, 1 run, 2 halted
    int m_mode;
    logic [31:0] m_pc, m_ipc, m_p4, m_instr, m_fpc;
    logic m_v, m_f;

    task automatic model_step(input logic r, input logic s, input logic v, input logic [31:0] t);
        if (r) begin
            m_mode = 0; m_pc = 0; m_v = 0; m_ipc = 0; m_p4 = 0; m_instr = NOP; m_f = 0; m_fpc = 0;
        end else if (m_mode != 1) begin
            m_mode = (m_mode == 0) ? 1 : 2;
            m_v = 0; m_instr = NOP;
        end else if (v) begin
            m_v = 0; m_instr = NOP;
            if (t % 4 == 0) m_pc = t;
            else begin m_mode = 2; m_f = 1; m_fpc = t; end
        end else if (!s) begin
            m_v = 1; m_ipc = m_pc; m_p4 = m_pc + 4; m_instr = mem(m_pc); m_pc = m_pc + 4;
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [31:0] t,
                                input logic ev, input logic [31:0] ea, input logic [31:0] ep,
                                input logic [31:0] ep4, input logic [31:0] ei,
                                input logic ef, input logic [31:0] efp);
        vec_t x;
        x.rst = r; x.stl = s; x.rv = v; x.tgt = t;
        x.e_valid = ev; x.e_addr = ea; x.e_pc = ep; x.e_p4 = ep4; x.e_instr = ei;
        x.e_fault = ef; x.e_fpc = efp;
        return x;
    endfunction

    initial begin
        drive(1, 0, 0, 0);
        vecs.push_back(mk(1,0,0,0,     0, 32'h00, 0, 0, NOP, 0, 0));
        vecs.push_back(mk(0,0,0,0,     0, 32'h00, 0, 0, NOP, 0, 0));
        vecs.push_back(mk(0,0,0,0,     1, 32'h04, 32'h00, 32'h04, mem(32'h00), 0, 0));
        vecs.push_back(mk(0,0,0,0,     1, 32'h08, 32'h04, 32'h08, mem(32'h04), 0, 0));
        vecs.push_back(mk(0,0,0,0,     1, 32'h0C, 32'h08, 32'h0C, mem(32'h08), 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,0,0, 1, 32'h0C, 32'h08, 32'h0C, mem(32'h08), 0, 0));
        vecs.push_back(mk(0,0,0,0,     1, 32'h10, 32'h0C, 32'h10, mem(32'h0C), 0, 0));
        vecs.push_back(mk(0,0,0,0,     1, 32'h14, 32'h10, 32'h14, mem(32'h10), 0, 0));
        vecs.push_back(mk(0,1,1,32'h40,0, 32'h40, 32'h10, 32'h14, NOP, 0, 0));
        vecs.push_back(mk(0,0,0,0,     1, 32'h44, 32'h40, 32'h44, mem(32'h40), 0, 0));
        vecs.push_back(mk(0,0,1,32'h42,0, 32'h44, 32'h40, 32'h44, NOP, 1, 32'h42));
        vecs.push_back(mk(0,1,1,32'h04,0, 32'h44, 32'h40, 32'h44, NOP, 1, 32'h42));
        vecs.push_back(mk(0,0,1,32'h08,0, 32'h44, 32'h40, 32'h44, NOP, 1, 32'h42));
        vecs.push_back(mk(0,1,0,0,     0, 32'h44, 32'h40, 32'h44, NOP, 1, 32'h42));
        vecs.push_back(mk(0,0,0,0,     0, 32'h44, 32'h40, 32'h44, NOP, 1, 32'h42));
        vecs.push_back(mk(0,0,1,32'h43,0, 32'h44, 32'h40, 32'h44, NOP, 1, 32'h42));
        vecs.push_back(mk(1,1,1,32'h80,0, 32'h00, 0, 0, NOP, 0, 0));
        vecs.push_back(mk(0,0,0,0,     0, 32'h00, 0, 0, NOP, 0, 0));
        vecs.push_back(mk(0,0,0,0,     1, 32'h04, 32'h00, 32'h04, mem(32'h00), 0, 0));
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].tgt);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_pc,
                      vecs[i].e_p4, vecs[i].e_instr, vecs[i].e_fault, vecs[i].e_fpc);
        end

        // wrap-around from 0xFFFF_FFF8
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("wrap boot valid", {31'd0, w_valid}, 32'd0);
        tick();
        chk("wrap pc0", w_pc, 32'hFFFF_FFF8);
        chk("wrap instr0", w_instr, mem(32'hFFFF_FFF8));
        tick();
        chk("wrap pc1", w_pc, 32'hFFFF_FFFC);
        chk("wrap p4_1", w_p4, 32'h0000_0000);
        tick();
        chk("wrap pc2", w_pc, 32'h0000_0000);
        chk("wrap addr", w_addr, 32'h0000_0004);
        chk("wrap fault", {31'd0, w_fault}, 32'd0);

        // randomized run against the model
        drive(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        tick();
        for (int c = 0; c < 400; c++) begin
            logic r, s, v;
            logic [31:0] t;
            r = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 7) == 0);
            t = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 9) == 0) t[1:0] = 2'($urandom_range(1, 3));
            drive(r, s, v, t);
            model_step(r, s, v, t);
            tick();
            check_all($sformatf("rnd%0d", c), m_v, m_pc, m_ipc, m_p4, m_instr, m_f, m_fpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
